// File: rtl/simple_div_128by64_pkg.sv
// Shared definitions for the 2W-by-W sequential restoring divider.
package simple_div_128by64_pkg;
    localparam int DEF_W = 64;
    localparam int CNT_W = $clog2(DEF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/simple_div_128by64_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module simple_div_step
    import simple_div_128by64_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   r,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         q_bit
);
    // R stays below the divisor, so the top bit of t is always zero in practice;
    // carrying it keeps the compare exact for any R the register can hold.
    logic [W+1:0] t;

    always_comb begin
        t      = {r, in_bit};
        q_bit  = (t >= {2'b00, divisor});
        r_next = q_bit ? (W+1)'(t - {2'b00, divisor}) : (W+1)'(t);
    end
endmodule

// File: rtl/simple_div_128by64.sv
// Sequential 2W/W restoring divider, one quotient bit per clock, valid/ready on both sides.
module simple_div_128by64
    import simple_div_128by64_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  dividend,
    input  logic [W-1:0]    divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    quotient,
    output logic [W-1:0]    remainder,
    output logic            div_zero,
    output logic            overflow
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, next_state;
    logic [W:0]    r_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  div_q;
    logic [CW-1:0] cnt;
    logic [W:0]    r_nxt;
    logic          q_bit;
    logic          accept, dz_in, ovf_in;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dz_in     = (divisor == '0);
    assign ovf_in    = (dividend[2*W-1:W] >= divisor);

    simple_div_step #(.W(W)) u_step (
        .r       (r_q),
        .in_bit  (q_q[W-1]),
        .divisor (div_q),
        .r_next  (r_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = (dz_in || ovf_in) ? DONE : CALC;
            CALC: if (cnt == LAST) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            q_q       <= '0;
            div_q     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            div_q <= divisor;
            cnt   <= '0;
            r_q   <= {1'b0, dividend[2*W-1:W]};
            q_q   <= dividend[W-1:0];
            // Error cases resolve on the accept edge and skip the iteration loop.
            if (dz_in) begin
                quotient  <= '1;
                remainder <= dividend[W-1:0];
                div_zero  <= 1'b1;
                overflow  <= 1'b0;
            end else if (ovf_in) begin
                quotient  <= '1;
                remainder <= '0;
                div_zero  <= 1'b0;
                overflow  <= 1'b1;
            end
        end else if (state == CALC) begin
            r_q <= r_nxt;
            q_q <= {q_q[W-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                quotient  <= {q_q[W-2:0], q_bit};
                remainder <= r_nxt[W-1:0];
                div_zero  <= 1'b0;
                overflow  <= 1'b0;
            end
        end
    end
endmodule
